// File: rtl/lr35902_sio_link_pkg.sv
// Shared constants and helpers for the LR35902 serial port (SB/SC) with link-cable side.
package lr35902_sio_link_pkg;

   // CPU-side register select and SC bit positions
   localparam logic SIO_ADR_SC   = 1'b0;
   localparam logic SIO_ADR_SB   = 1'b1;
   localparam int   SC_START_BIT = 7;
   localparam int   SC_CLK_BIT   = 0;
   localparam int   SIO_BITS     = 8;

   // Which shifter is active this cycle, derived from tstart and sclk
   typedef enum logic [1:0] {
      MODE_IDLE = 2'd0,
      MODE_INT  = 2'd1,
      MODE_EXT  = 2'd2
   } sio_mode_t;

   // SC as seen by the CPU: unused bits read back as ones
   function automatic logic [7:0] sc_read_value(input logic tstart, input logic sclk);
      return {tstart, 6'h3f, sclk};
   endfunction

endpackage

// File: rtl/lr35902_sio_sync.sv
// Multi-flop synchronizer for an asynchronous level, with one-cycle rise/fall pulses
// derived from the synchronized level.
module lr35902_sio_sync #(
   parameter int   SYNC_LEN  = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [SYNC_LEN-1:0] chain;
   logic                prev;
   logic                level;

   assign level = chain[SYNC_LEN-1];

   // Shift the async input through the chain and remember the last synchronized level
   always_ff @(posedge clk) begin
      // NOTE: the reset is synchronous, so it lives inside the clocked branch and the
      // sensitivity list holds only the clock.
      if (reset) begin
         chain <= {SYNC_LEN{RESET_VAL}};
         prev  <= RESET_VAL;
      end else begin
         chain <= {chain[SYNC_LEN-2:0], d};
         prev  <= level;
      end
   end

   assign rise = level & ~prev;
   assign fall = ~level & prev;

endmodule

// File: rtl/lr35902_sio_link.sv
// LR35902 serial port: SB/SC register file, internal clock divider, bit counter and
// MSB-first shifter, with master (sck_out) and slave (synchronized sck_in) wire sides.
module lr35902_sio_link
   import lr35902_sio_link_pkg::*;
#(
   parameter int DIV_BITS = 9,
   parameter int SYNC_LEN = 2
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] dout,
   input  logic [7:0] din,
   input  logic       adr,
   input  logic       read,
   input  logic       write,
   output logic       irq,
   input  logic       sck_in,
   output logic       sck_out,
   output logic       sck_oe,
   input  logic       sin,
   output logic       sout
);

   localparam int                  HALF    = 2 ** (DIV_BITS - 1);
   localparam logic [DIV_BITS-1:0] HALF_M1 = DIV_BITS'(HALF - 1);
   localparam logic [DIV_BITS-1:0] FULL_M1 = {DIV_BITS{1'b1}};
   localparam logic [3:0]          LAST_BIT = 4'(SIO_BITS - 1);
   localparam logic [3:0]          NUM_BITS = 4'(SIO_BITS);

   // Architectural and pipeline state
   logic [7:0]          sb;
   logic                tstart;
   logic                sclk;
   logic [3:0]          bit_cnt;
   logic [DIV_BITS-1:0] div;
   logic                pwrite;
   logic                sck_q;

   // Synchronized wire-side inputs
   logic [SYNC_LEN-1:0] sin_chain;
   logic                sin_s;
   logic                sck_rise;
   logic                sck_fall;

   // Per-cycle decode
   sio_mode_t  mode;
   logic       int_start;
   logic       int_rise;
   logic       int_fall;
   logic       shift_en;
   logic       fall_en;
   logic       done;
   logic [7:0] sb_shift;
   logic       commit;
   logic       sb_wr;
   logic       sc_wr;
   logic       busy_after;

   lr35902_sio_sync #(
      .SYNC_LEN  (SYNC_LEN),
      .RESET_VAL (1'b1)
   ) u_sck_sync (
      .clk   (clk),
      .reset (reset),
      .d     (sck_in),
      .rise  (sck_rise),
      .fall  (sck_fall)
   );

   // Plain flop chain bringing sin into the clk domain
   always_ff @(posedge clk) begin
      if (reset) begin
         sin_chain <= {SYNC_LEN{1'b1}};
      end else begin
         sin_chain <= {sin_chain[SYNC_LEN-2:0], sin};
      end
   end

   assign sin_s = sin_chain[SYNC_LEN-1];

   // Decode the active mode, serial clock events and the CPU write commit
   always_comb begin
      // NOTE: every signal gets a default before any condition so no path leaves it
      // unassigned, which would otherwise infer a latch.
      mode       = MODE_IDLE;
      int_start  = 1'b0;
      int_rise   = 1'b0;
      int_fall   = 1'b0;
      shift_en   = 1'b0;
      fall_en    = 1'b0;
      done       = 1'b0;
      sb_shift   = {sb[6:0], sin_s};
      commit     = pwrite && !write;
      sb_wr      = 1'b0;
      sc_wr      = 1'b0;
      busy_after = 1'b0;

      if (tstart) begin
         mode = sclk ? MODE_INT : MODE_EXT;
      end

      if (mode == MODE_INT) begin
         int_start = (div == '0);
         int_rise  = (div == HALF_M1);
         int_fall  = (div == FULL_M1) && (bit_cnt < NUM_BITS);
      end

      shift_en = int_rise || ((mode == MODE_EXT) && sck_rise);
      fall_en  = int_fall || ((mode == MODE_EXT) && sck_fall);
      done     = shift_en && (bit_cnt == LAST_BIT);

      // A transfer that completes this cycle counts as idle for a concurrent write
      busy_after = tstart && !done;

      sb_wr = commit && (adr == SIO_ADR_SB);
      sc_wr = commit && (adr == SIO_ADR_SC);
   end

   // Register file, divider, bit counter and shifter; CPU writes are applied last so a
   // write committing alongside completion takes precedence.
   always_ff @(posedge clk) begin
      if (reset) begin
         dout    <= 8'h00;
         irq     <= 1'b0;
         sck_q   <= 1'b1;
         sout    <= 1'b1;
         sb      <= 8'h00;
         tstart  <= 1'b0;
         sclk    <= 1'b0;
         bit_cnt <= 4'd0;
         div     <= '0;
         pwrite  <= 1'b0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every right-hand side
         // sees the pre-edge values, e.g. a read returns SB/SC from before this edge.
         pwrite <= write;
         irq    <= 1'b0;

         if (read) begin
            dout <= (adr == SIO_ADR_SB) ? sb : sc_read_value(tstart, sclk);
         end

         if (mode == MODE_INT) begin
            div <= div + 1'b1;
         end

         if (int_start || int_fall) begin
            sck_q <= 1'b0;
         end

         if (fall_en) begin
            sout <= sb[7];
         end

         if (shift_en) begin
            sb      <= sb_shift;
            bit_cnt <= bit_cnt + 4'd1;
            sck_q   <= 1'b1;
         end

         if (done) begin
            tstart <= 1'b0;
            irq    <= 1'b1;
         end

         if (sb_wr && !busy_after) begin
            sb   <= din;
            sout <= din[7];
         end

         if (sc_wr) begin
            sclk <= din[SC_CLK_BIT];
            if (!busy_after && din[SC_START_BIT]) begin
               tstart  <= 1'b1;
               bit_cnt <= 4'd0;
               div     <= '0;
               sck_q   <= 1'b1;
               sout    <= done ? sb_shift[7] : sb[7];
            end else if (busy_after && !din[SC_START_BIT]) begin
               tstart <= 1'b0;
               sck_q  <= 1'b1;
            end
         end
      end
   end

   // The master clock only reaches the pin while an internal-clock transfer runs
   assign sck_out = sck_q | ~(tstart & sclk);
   assign sck_oe  = sclk;

endmodule

// File: tb/tb_lr35902_sio_link.sv
// Scoreboard bench for lr35902_sio_link with DIV_BITS=4 (HALF=8, FULL=16).
module tb_lr35902_sio_link;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] dout;
   logic [7:0] din;
   logic       adr;
   logic       read;
   logic       write;
   logic       irq;
   logic       sck_in;
   logic       sck_out;
   logic       sck_oe;
   logic       sin;
   logic       sout;

   logic       sin_invert;
   logic       sin_fixed;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;

   // scoreboard queues
   logic [7:0] exp_rd_val[$];
   string      exp_rd_name[$];
   logic       exp_sout[$];
   logic       sout_en = 1'b0;

   // monitor state
   logic       rd_d      = 1'b0;
   logic       irq_prev  = 1'b0;
   logic       sck_prev  = 1'b1;
   int         irq_cnt   = 0;
   int         irq_cyc   = 0;
   int         rise_cnt  = 0;
   int         commit_cyc = 0;

   assign sin = sin_invert ? ~sout : sin_fixed;

   lr35902_sio_link #(
      .DIV_BITS (4),
      .SYNC_LEN (2)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .dout    (dout),
      .din     (din),
      .adr     (adr),
      .read    (read),
      .write   (write),
      .irq     (irq),
      .sck_in  (sck_in),
      .sck_out (sck_out),
      .sck_oe  (sck_oe),
      .sin     (sin),
      .sout    (sout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      rd_d <= read;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compares read data, sout per sck_out rise, and irq pulse width
   always @(negedge clk) begin
      if (rd_d === 1'b1) begin
         if (exp_rd_val.size() == 0) begin
            check("unexpected_read", 32'(dout), 32'hffff_ffff);
         end else begin
            check(exp_rd_name.pop_front(), 32'(dout), 32'(exp_rd_val.pop_front()));
         end
      end
      if (irq === 1'b1) begin
         irq_cnt++;
         irq_cyc = cyc;
         check("irq_width", 32'(irq_prev), 32'd0);
      end
      irq_prev = irq;
      if (sck_out === 1'b1 && sck_prev === 1'b0) begin
         rise_cnt++;
         if (sout_en) begin
            if (exp_sout.size() == 0) begin
               check("extra_sck_rise", 32'(sout), 32'hffff_ffff);
            end else begin
               check("sout_bit", 32'(sout), 32'(exp_sout.pop_front()));
            end
         end
      end
      sck_prev = sck_out;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic a, input logic [7:0] exp, input string name);
      exp_rd_val.push_back(exp);
      exp_rd_name.push_back(name);
      adr  = a;
      read = 1'b1;
      tick();
      read = 1'b0;
      tick();
   endtask

   task automatic do_write(input logic a, input logic [7:0] d);
      adr   = a;
      din   = d;
      write = 1'b1;
      tick();
      write = 1'b0;
      tick();
      commit_cyc = cyc;
   endtask

   task automatic wait_rises(input int target, input int budget);
      int k = 0;
      while (rise_cnt < target && k < budget) begin
         tick();
         k++;
      end
      if (rise_cnt < target) check("timeout_sck_rise", 32'(rise_cnt), 32'(target));
   endtask

   task automatic wait_irq(input int target, input int budget);
      int k = 0;
      while (irq_cnt < target && k < budget) begin
         tick();
         k++;
      end
      if (irq_cnt < target) check("timeout_irq", 32'(irq_cnt), 32'(target));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int irq_base;
      int rise8_cyc;
      logic [7:0] pat;

      reset = 1'b1; din = 8'h00; adr = 1'b0; read = 1'b0; write = 1'b0;
      sck_in = 1'b1; sin_invert = 1'b0; sin_fixed = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // reset state
      check("rst_sck_out", 32'(sck_out), 32'd1);
      check("rst_sout", 32'(sout), 32'd1);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_sck_oe", 32'(sck_oe), 32'd0);
      do_read(1'b1, 8'h00, "rst_sb");
      do_read(1'b0, 8'h7e, "rst_sc");

      // internal transfer, sin looped back inverted
      sin_invert = 1'b1;
      do_write(1'b1, 8'ha5);
      check("sb_wr_sout", 32'(sout), 32'd1);
      pat = 8'ha5;
      for (int i = 7; i >= 0; i--) exp_sout.push_back(pat[i]);
      sout_en = 1'b1;
      base = rise_cnt;
      irq_base = irq_cnt;
      do_write(1'b0, 8'h81);
      check("int_sck_oe", 32'(sck_oe), 32'd1);
      wait_irq(irq_base + 1, 200);
      check("int_irq_latency", 32'(irq_cyc - commit_cyc), 32'd120);
      repeat (4) tick();
      sout_en = 1'b0;
      check("int_rises", 32'(rise_cnt - base), 32'd8);
      check("int_irq_count", 32'(irq_cnt - irq_base), 32'd1);
      check("int_sck_idle", 32'(sck_out), 32'd1);
      do_read(1'b1, 8'h5a, "int_sb");
      do_read(1'b0, 8'h7f, "int_sc");

      // external transfer, sin held high
      sin_invert = 1'b0;
      sin_fixed  = 1'b1;
      base = rise_cnt;
      irq_base = irq_cnt;
      do_write(1'b0, 8'h80);
      check("ext_sck_oe", 32'(sck_oe), 32'd0);
      rise8_cyc = 0;
      for (int p = 0; p < 8; p++) begin
         sck_in = 1'b0;
         repeat (6) tick();
         sck_in = 1'b1;
         rise8_cyc = cyc;
         repeat (6) tick();
      end
      wait_irq(irq_base + 1, 20);
      check("ext_irq_delay", 32'(irq_cyc - rise8_cyc), 32'd3);
      check("ext_irq_count", 32'(irq_cnt - irq_base), 32'd1);
      check("ext_no_sck_out", 32'(rise_cnt - base), 32'd0);
      do_read(1'b1, 8'hff, "ext_sb");
      do_read(1'b0, 8'h7e, "ext_sc");

      // internal transfer: SB write ignored mid-transfer, then abort after 3rd rise
      sin_fixed = 1'b0;
      do_write(1'b1, 8'hc3);
      base = rise_cnt;
      irq_base = irq_cnt;
      do_write(1'b0, 8'h81);
      wait_rises(base + 1, 100);
      do_write(1'b1, 8'h00);
      wait_rises(base + 3, 100);
      do_write(1'b0, 8'h01);
      repeat (40) tick();
      check("abort_no_irq", 32'(irq_cnt - irq_base), 32'd0);
      check("abort_rises", 32'(rise_cnt - base), 32'd3);
      check("abort_sck_out", 32'(sck_out), 32'd1);
      do_read(1'b1, 8'h18, "abort_sb");
      do_read(1'b0, 8'h7f, "abort_sc");

      // sck_in edges while idle in external mode
      do_write(1'b0, 8'h00);
      irq_base = irq_cnt;
      for (int p = 0; p < 4; p++) begin
         sck_in = 1'b0;
         repeat (3) tick();
         sck_in = 1'b1;
         repeat (3) tick();
      end
      repeat (5) tick();
      check("idle_edges_no_irq", 32'(irq_cnt - irq_base), 32'd0);
      do_read(1'b1, 8'h18, "idle_edges_sb");

      // reset in the middle of the 5th bit, then a full transfer
      sin_fixed = 1'b1;
      do_write(1'b1, 8'h3c);
      base = rise_cnt;
      irq_base = irq_cnt;
      do_write(1'b0, 8'h81);
      wait_rises(base + 4, 200);
      repeat (4) tick();
      reset = 1'b1;
      tick();
      check("mid_rst_dout", 32'(dout), 32'd0);
      check("mid_rst_irq", 32'(irq), 32'd0);
      check("mid_rst_sck_out", 32'(sck_out), 32'd1);
      check("mid_rst_sck_oe", 32'(sck_oe), 32'd0);
      check("mid_rst_sout", 32'(sout), 32'd1);
      reset = 1'b0;
      tick();
      do_read(1'b1, 8'h00, "mid_rst_sb");
      do_read(1'b0, 8'h7e, "mid_rst_sc");
      repeat (20) tick();
      check("mid_rst_no_irq", 32'(irq_cnt - irq_base), 32'd0);
      do_write(1'b0, 8'h81);
      wait_irq(irq_base + 1, 200);
      check("post_rst_irq_latency", 32'(irq_cyc - commit_cyc), 32'd120);
      repeat (4) tick();
      do_read(1'b1, 8'hff, "post_rst_sb");
      do_read(1'b0, 8'h7f, "post_rst_sc");

      repeat (2) tick();
      check("read_queue_drained", 32'(exp_rd_val.size()), 32'd0);
      check("sout_queue_drained", 32'(exp_sout.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
